// File: rtl/fft_stage_scheduler.sv
// rtl/fft_stage_scheduler.sv - stage sequencer and credit gate for a streaming radix-2 FFT core
//
// Purpose: steps the twiddle-multiply core through NUM_STAGES passes of an
// FFT_N-point frame. It admits source samples into the core, produces the
// per-sample twiddle ROM index, limits the number of samples in flight to
// MAX_INFLIGHT, and advances the stage once every sample of a pass has come
// back out of the core.
//
// Optional feature: define FFT_SCHED_STALL_CNT_EN to add a saturating
// 32-bit stall_cycles output.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               begin a frame (honoured only when idle)
//   busy, done          frame in progress / one-cycle frame-complete pulse
//   stage               current pass index
//   err                 sticky: a core completion arrived with nothing in flight
//   src_valid/ready     upstream sample handshake, src_data = {real, imag}
//   core_valid/ready    sample handshake toward the core, core_data = src_data
//   core_tw_idx         twiddle ROM index for the sample being offered
//   res_valid/ready     core output handshake (observed only)
//   stall_cycles        RUN cycles with src_valid && !src_ready (optional)

module fft_stage_scheduler #(
  parameter int FFT_N        = 256,
  parameter int NUM_STAGES   = $clog2(FFT_N),
  parameter int MAX_INFLIGHT = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_STAGES)-1:0] stage,
  output logic                          err,
  input  logic                          src_valid,
  output logic                          src_ready,
  input  logic [2*DATA_WIDTH-1:0]       src_data,
  output logic                          core_valid,
  input  logic                          core_ready,
  output logic [2*DATA_WIDTH-1:0]       core_data,
  output logic [$clog2(FFT_N)-2:0]      core_tw_idx,
  input  logic                          res_valid,
  input  logic                          res_ready
`ifdef FFT_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int SW  = $clog2(NUM_STAGES);
  localparam int IW  = $clog2(FFT_N) + 1;       // counts 0..FFT_N inclusive
  localparam int TWW = $clog2(FFT_N) - 1;
  localparam int FW  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q;
  logic [IW-1:0] issue_cnt, done_cnt;
  logic [FW-1:0] inflight;
  logic          err_q;

  logic gate, issue_hs, comp, comp_ok, comp_bad;
  logic start_acc, last_issue, drain_done, last_stage;

  // The gate depends only on registered state, so core_valid never
  // combinationally follows core_ready.
  assign gate = (state_q == S_RUN) && (issue_cnt < IW'(FFT_N)) &&
                (inflight < FW'(MAX_INFLIGHT));

  assign core_valid = src_valid && gate;
  assign src_ready  = core_ready && gate;
  assign core_data  = src_data;
  assign issue_hs   = core_valid && core_ready;

  // A completion with nothing in flight is a protocol error; it must not
  // disturb the counters.
  assign comp     = res_valid && res_ready;
  assign comp_ok  = comp && (inflight != '0);
  assign comp_bad = comp && (inflight == '0);

  assign start_acc  = (state_q == S_IDLE) && start;
  assign last_issue = issue_hs && (issue_cnt == IW'(FFT_N - 1));
  assign drain_done = (state_q == S_DRAIN) && (done_cnt == IW'(FFT_N));
  assign last_stage = (stage_q == SW'(NUM_STAGES - 1));

  // Butterfly span halves each pass: index = (k mod half) << stage.
  assign core_tw_idx = TWW'((32'(issue_cnt) &
                       ((32'(FFT_N) >> (32'(stage_q) + 32'd1)) - 32'd1)) << stage_q);

  assign stage = stage_q;
  assign err   = err_q;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_done) state_d = last_stage ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      issue_cnt <= '0;
      done_cnt  <= '0;
      inflight  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_acc) begin
        stage_q   <= '0;
        issue_cnt <= '0;
        done_cnt  <= '0;
        err_q     <= 1'b0;
      end else begin
        if (issue_hs) issue_cnt <= issue_cnt + 1'b1;
        if (comp_ok && (state_q == S_RUN || state_q == S_DRAIN))
          done_cnt <= done_cnt + 1'b1;
        if (drain_done) begin
          issue_cnt <= '0;
          done_cnt  <= '0;
          if (!last_stage) stage_q <= stage_q + 1'b1;
        end
      end

      // A bad completion on the same cycle as a start still flags.
      if (comp_bad) err_q <= 1'b1;

      case ({issue_hs, comp_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef FFT_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cycles <= '0;
    end else if ((state_q == S_RUN) && src_valid && !src_ready &&
                 (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// tb/tb_fft_stage_scheduler.sv - directed self-checking bench for fft_stage_scheduler

module tb_fft_stage_scheduler;

  localparam int N  = 8;
  localparam int MI = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic [1:0]    stage;
  logic          src_valid, src_ready;
  logic [2*DW-1:0] src_data, core_data;
  logic          core_valid, core_ready;
  logic [1:0]    core_tw_idx;
  logic          res_valid, res_ready;
`ifdef FFT_SCHED_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  fft_stage_scheduler #(
    .FFT_N(N), .MAX_INFLIGHT(MI), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .stage(stage), .err(err),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data),
    .core_tw_idx(core_tw_idx), .res_valid(res_valid), .res_ready(res_ready)
`ifdef FFT_SCHED_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sv, cr, rv, rr;
    logic       busy, done;
    logic [1:0] stage;
    logic       cv, sr;
    logic [1:0] tw;
    logic       err;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read 1 ns later.
  task automatic drive(input logic st, sv, cr, rv, rr);
    @(negedge clk);
    start = st; src_valid = sv; core_ready = cr; res_valid = rv; res_ready = rr;
    src_data = $urandom;
    #1;
  endtask

  // Hand-derived twiddle indices for an 8-point FFT.
  function automatic int exp_tw(input int s, input int k);
    case (s)
      0:       return k % 4;
      1:       return (k % 2) * 2;
      default: return 0;
    endcase
  endfunction

  // Streams with the core output echoing each issue two cycles later.
  task automatic run_echo(input int stop_issues, output int issues, output int dones,
                          output int busy_low, output int last_comp,
                          output int done_cyc, output int first_cv);
    logic [1:0] pipe;
    logic hs;
    pipe = 2'b00; issues = 0; dones = 0; busy_low = 0;
    last_comp = -1; done_cyc = -1; first_cv = -1;
    for (int c = 1; c < 200 && done_cyc < 0 && issues < stop_issues; c++) begin
      drive(1'b0, 1'b1, 1'b1, pipe[1], 1'b1);
      if (res_valid) last_comp = c;
      if (core_valid && first_cv < 0) first_cv = c;
      if (done) begin
        dones++;
        done_cyc = c;
      end else if (!busy) begin
        busy_low++;
      end
      hs = core_valid && core_ready;
      if (hs) begin
        chk("tw_idx", core_tw_idx, exp_tw(issues / N, issues % N));
        chk("issue_stage", stage, issues / N);
        issues++;
      end
      pipe = {pipe[0], hs};
    end
  endtask

  int issues, dones, busy_low, last_comp, done_cyc, first_cv, extra;

  initial begin
    //                st sv cr rv rr  bsy dn stg cv sr tw err
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd1,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd2,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd3,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd0,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd1,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd2,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,1'b0,2'd2,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd2,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd3,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b1,1'b1,2'd3,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[16] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[17] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[18] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0};
    vecs[19] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd1,1'b1,1'b1,2'd0,1'b0};
    vecs[20] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd1,1'b1,1'b1,2'd2,1'b0};
    vecs[21] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,2'd1,1'b1,1'b1,2'd0,1'b0};

    rst = 1'b1; start = 1'b0; src_valid = 1'b0; core_ready = 1'b0;
    res_valid = 1'b0; res_ready = 1'b0; src_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cycle-accurate sequence: start, credit limit, simultaneous issue and
    // completion at 4 and 3 in flight, mid-frame start, drain, stage advance.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].st, vecs[i].sv, vecs[i].cr, vecs[i].rv, vecs[i].rr);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_done", i), done, vecs[i].done);
      chk($sformatf("v%0d_stage", i), stage, vecs[i].stage);
      chk($sformatf("v%0d_core_valid", i), core_valid, vecs[i].cv);
      chk($sformatf("v%0d_src_ready", i), src_ready, vecs[i].sr);
      chk($sformatf("v%0d_tw_idx", i), core_tw_idx, vecs[i].tw);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_core_data", i), core_data, src_data);
    end

    // Reset mid-frame, then reset state with inputs asking to issue.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    start = 1'b0; src_valid = 1'b1; core_ready = 1'b1; res_valid = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stage", stage, 0);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_err", err, 0);

    // Full frame, always ready.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    run_echo(1000, issues, dones, busy_low, last_comp, done_cyc, first_cv);
    chk("frame_done_seen", done_cyc > 0, 1);
    chk("frame_issues", issues, 24);
    chk("frame_first_cv_latency", first_cv, 1);
    chk("frame_busy_low_cycles", busy_low, 0);
    chk("frame_done_latency", done_cyc - last_comp, 2);
    chk("frame_done_busy", busy, 0);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (done) extra++;
    end
    chk("frame_done_pulses", dones + extra, 1);
    chk("frame_err", err, 0);

    // Spurious completion in IDLE sets err; the next start clears it.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_spurious_err", err, 1);
    chk("idle_spurious_busy", busy, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    run_echo(16, issues, dones, busy_low, last_comp, done_cyc, first_cv);
    chk("restart_err_cleared", err, 0);
    chk("drain_issues", issues, 16);

    // Now in stage 1 DRAIN with two completions outstanding.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("drain_stage", stage, 1);
    chk("drain_busy", busy, 1);
    chk("drain_core_valid", core_valid, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("drain_rst_busy", busy, 0);
    chk("drain_rst_stage", stage, 0);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      if (done) extra++;
    end
    chk("drain_rst_no_done", extra, 0);

`ifdef FFT_SCHED_STALL_CNT_EN
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("stall_count", stall_cycles, 10);
    run_echo(1000, issues, dones, busy_low, last_comp, done_cyc, first_cv);
    chk("stall_frame_done_seen", done_cyc > 0, 1);
    chk("stall_hold_after_done", stall_cycles, 10);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_cleared_on_start", stall_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
